// File: rtl/interfaz_pkg.sv
`default_nettype none
// ============================================================================
// Module  : interfaz_pkg (package)
// Purpose : Shared definitions for the data-side bus stage: peripheral base
//           addresses, EVT register bit positions, the decoded-region enum
//           and an address decode helper.
// Ports   : n/a (package)
// Revision: 1.0 - initial release
// ============================================================================
package interfaz_pkg;

  localparam logic [31:0] BASE_BTN  = 32'h0001_0000;
  localparam logic [31:0] BASE_EVT  = 32'h0001_0004;
  localparam logic [31:0] BASE_TICK = 32'h0001_0008;
  localparam logic [31:0] BASE_VID  = 32'h0001_000C;

  localparam int EVT_OVF_BIT = 8;

  typedef enum logic [2:0] {
    REG_RAM  = 3'd0,
    REG_BTN  = 3'd1,
    REG_EVT  = 3'd2,
    REG_TICK = 3'd3,
    REG_VID  = 3'd4,
    REG_NONE = 3'd5
  } region_t;

  // Peripheral registers are decoded on the word address, so the byte
  // offset inside a register word is ignored just as it is for RAM.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
    logic [31:0] word_addr;
    region_t     r;
    word_addr = {addr[31:2], 2'b00};
    if (addr[31:17] != 15'd0) begin
      r = REG_NONE;
    end else if (addr < ram_bytes) begin
      r = REG_RAM;
    end else begin
      case (word_addr)
        BASE_BTN:  r = REG_BTN;
        BASE_EVT:  r = REG_EVT;
        BASE_TICK: r = REG_TICK;
        BASE_VID:  r = REG_VID;
        default:   r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_video.sv
`default_nettype none
// ============================================================================
// Module  : fifo_video
// Purpose : Synchronous FIFO buffering commands for the video/tile renderer.
//           A push while full is accepted only if a pop happens in the same
//           cycle; pops while empty are ignored. All storage clears on reset
//           so the head output reads 0 when empty after reset.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           push, din        - write request and data
//           pop              - read request (ignored when empty)
//           dout             - head entry
//           full, empty      - status flags
//           count            - occupancy 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module fifo_video #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;   // power-of-2 depth: wraps naturally
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/interfaz_memoria_datos.sv
`default_nettype none
// ============================================================================
// Module  : interfaz_memoria_datos
// Purpose : Data-side bus stage behind the single-cycle core. Decodes the
//           ALU byte address into data RAM, button/event registers, a frame
//           tick counter and a command FIFO to the video renderer.
//           Optional feature macro: INTERFAZ_DEBOUNCE_EN (per-button
//           debounce counters; otherwise debounced state = synchronizer).
// Ports   : clk, rst_n              - clock, asynchronous active-low reset
//           memWr, direc, datoOut   - store strobe, byte address, store data
//           datoIn                  - load data (combinational from direc)
//           botones                 - raw button pins, active-high
//           video_dato/valido/listo - renderer command handshake
// Revision: 1.0 - initial release
// ============================================================================
module interfaz_memoria_datos
  import interfaz_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 833333,
  parameter int DEB_CYCLES = 65536,
  parameter int NUM_BTN    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memWr,
  input  logic [31:0]        direc,
  input  logic [31:0]        datoOut,
  output logic [31:0]        datoIn,
  input  logic [NUM_BTN-1:0] botones,
  output logic [31:0]        video_dato,
  output logic               video_valido,
  input  logic               video_listo
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int          TD_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  region_t region;
  logic    wr_evt;
  logic    wr_tick;
  logic    wr_vid;

  assign region  = decode_region(direc, RAM_BYTES);
  assign wr_evt  = memWr && (region == REG_EVT);
  assign wr_tick = memWr && (region == REG_TICK);
  assign wr_vid  = memWr && (region == REG_VID);

  // ------------------------------------------------------------------- RAM
  // Not reset: contents survive a reset pulse.
  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = direc[RAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (memWr && (region == REG_RAM)) begin
      ram[ram_idx] <= datoOut;
    end
  end

  // --------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb_prev <= '0;
    end else begin
      sync1    <= botones;
      sync2    <= sync1;
      deb_prev <= deb;
    end
  end

`ifdef INTERFAZ_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic             state;

    // The state flips on the DEB_CYCLES-th consecutive cycle that the
    // synchronized input disagrees with it; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        state <= 1'b0;
      end else if (sync2[i] != state) begin
        if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
          state <= sync2[i];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[i] = state;
  end
`else
  assign deb = sync2;
`endif

  // ---------------------------------------------------------------- events
  logic [NUM_BTN-1:0] evt_btn;
  logic               evt_ovf;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_clr;
  logic               ovf_set;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign btn_rise = deb & ~deb_prev;
  assign btn_clr  = wr_evt ? datoOut[NUM_BTN-1:0] : '0;
  // A push into a full FIFO is only lost when no pop frees a slot.
  assign ovf_set  = wr_vid && fifo_full && !(video_valido && video_listo);

  // Set wins over clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_btn <= '0;
      evt_ovf <= 1'b0;
    end else begin
      evt_btn <= (evt_btn & ~btn_clr) | btn_rise;
      evt_ovf <= (evt_ovf & ~(wr_evt && datoOut[EVT_OVF_BIT])) | ovf_set;
    end
  end

  // ------------------------------------------------------------ frame tick
  logic [TD_W-1:0] tick_div;
  logic [31:0]     tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_div <= '0;
      tick     <= '0;
    end else if (wr_tick) begin
      tick_div <= '0;
      tick     <= '0;
    end else if (tick_div == TD_W'(TICK_DIV - 1)) begin
      tick_div <= '0;
      tick     <= tick + 32'd1;
    end else begin
      tick_div <= tick_div + 1'b1;
    end
  end

  // ------------------------------------------------------------ video FIFO
  fifo_video #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_vid),
    .pop   (video_listo),
    .din   (datoOut),
    .dout  (video_dato),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign video_valido = !fifo_empty;

  // ------------------------------------------------------------- read mux
  logic [7:0] occ;
  assign occ = 8'(fifo_count);

  always_comb begin
    datoIn = '0;
    case (region)
      REG_RAM:  datoIn = ram[ram_idx];
      REG_BTN:  datoIn = 32'(deb);
      REG_EVT: begin
        datoIn[NUM_BTN-1:0]  = evt_btn;
        datoIn[EVT_OVF_BIT]  = evt_ovf;
      end
      REG_TICK: datoIn = tick;
      REG_VID:  datoIn = {fifo_full, 23'd0, occ};
      default:  datoIn = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_interfaz_memoria_datos.sv
`default_nettype none
// ============================================================================
// Module  : tb_interfaz_memoria_datos
// Purpose : Scoreboard bench. Stimulus pushes expected load data and
//           expected renderer words into queues; a monitor on the falling
//           edge pops and compares whenever a load is pending or the
//           renderer handshake completes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_interfaz_memoria_datos;

  localparam int NUM_BTN = 4;
  localparam logic [31:0] A_BTN  = 32'h0001_0000;
  localparam logic [31:0] A_EVT  = 32'h0001_0004;
  localparam logic [31:0] A_TICK = 32'h0001_0008;
  localparam logic [31:0] A_VID  = 32'h0001_000C;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               memWr;
  logic [31:0]        direc;
  logic [31:0]        datoOut;
  logic [31:0]        datoIn;
  logic [NUM_BTN-1:0] botones;
  logic [31:0]        video_dato;
  logic               video_valido;
  logic               video_listo;

  interfaz_memoria_datos #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .TICK_DIV   (4),
    .DEB_CYCLES (4),
    .NUM_BTN    (NUM_BTN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memWr        (memWr),
    .direc        (direc),
    .datoOut      (datoOut),
    .datoIn       (datoIn),
    .botones      (botones),
    .video_dato   (video_dato),
    .video_valido (video_valido),
    .video_listo  (video_listo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        rd_q[$];
  logic [31:0] vid_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compares pending loads and every completed renderer handshake.
  always @(negedge clk) begin
    if (rd_q.size() > 0) begin
      exp_t e;
      e = rd_q.pop_front();
      check(e.name, datoIn, e.val);
    end
    if (rst_n && video_valido && video_listo) begin
      if (vid_q.size() == 0) begin
        n_total++;
        $display("FAIL video_unexpected: got 0x%08h expected no word", video_dato);
      end else begin
        check("video_dato", video_dato, vid_q.pop_front());
      end
    end
  end

  // ----------------------------------------------------------- stimulus
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    memWr = 1'b1; direc = a; datoOut = d;
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] exp);
    exp_t e;
    @(posedge clk); #1;
    memWr = 1'b0; direc = a;
    e.name = name; e.val = exp;
    rd_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      memWr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; memWr = 1'b0; direc = '0; datoOut = '0;
    botones = '0; video_listo = 1'b0;

    // Reset state (checked while reset is held).
    idle(2);
    rd("rst_btn",  A_BTN,  32'h0);
    rd("rst_evt",  A_EVT,  32'h0);
    rd("rst_tick", A_TICK, 32'h0);
    rd("rst_vid",  A_VID,  32'h0);
    @(negedge clk); #1;
    check("rst_video_valido", {31'd0, video_valido}, 32'h0);
    check("rst_video_dato",   video_dato,            32'h0);
    rst_n = 1'b1;

    // RAM and unmapped space.
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_byte_off",  32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0002_0010, 32'h1234_5678);
    rd("unmapped_hi",   32'h0002_0010, 32'h0);
    rd("ram_no_alias",  32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0FFC, 32'hA5A5_A5A5);
    rd("ram_last",      32'h0000_0FFC, 32'hA5A5_A5A5);
    rd("past_ram",      32'h0000_1000, 32'h0);
    rd("unmapped_reg",  32'h0001_0010, 32'h0);

    // Button synchronizer latency and event register.
    @(posedge clk); #1;
    memWr = 1'b0; botones = 4'b0100;
    rd("btn_1cyc",  A_BTN, 32'h0);
    rd("btn_2cyc",  A_BTN, 32'h4);
    rd("evt_set",   A_EVT, 32'h4);
    wr(A_EVT, 32'h4);
    rd("evt_clr",   A_EVT, 32'h0);

    // Frame tick with TICK_DIV=4.
    wr(A_TICK, 32'hFFFF_0000);
    idle(20);
    rd("tick_20",     A_TICK, 32'd5);
    wr(A_TICK, 32'h1);
    rd("tick_reload", A_TICK, 32'd0);
    idle(3);
    rd("tick_4",      A_TICK, 32'd1);

    // Overflow: nine pushes into a depth-8 FIFO, ninth is lost.
    for (int k = 1; k <= 9; k++) begin
      wr(A_VID, 32'(k));
      if (k <= 8) vid_q.push_back(32'(k));
    end
    rd("vid_full",  A_VID, 32'h8000_0008);
    rd("evt_ovf",   A_EVT, 32'h0000_0100);
    @(posedge clk); #1;
    memWr = 1'b0; video_listo = 1'b1;
    idle(9);
    rd("vid_drained", A_VID, 32'h0);
    @(negedge clk); #1;
    check("valido_drained", {31'd0, video_valido}, 32'h0);
    video_listo = 1'b0;
    wr(A_EVT, 32'h0000_0100);
    rd("evt_ovf_clr", A_EVT, 32'h0);

    // Full FIFO with simultaneous push and pop.
    for (int k = 11; k <= 18; k++) begin
      wr(A_VID, 32'(k));
      vid_q.push_back(32'(k));
    end
    @(posedge clk); #1;
    memWr = 1'b1; direc = A_VID; datoOut = 32'd19; video_listo = 1'b1;
    vid_q.push_back(32'd19);
    rd("vid_pushpop", A_VID, 32'h8000_0008);
    video_listo = 1'b0;
    rd("evt_no_ovf",  A_EVT, 32'h0);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    video_listo = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valido", {31'd0, video_valido}, 32'h0);
    vid_q.delete();
    video_listo = 1'b0;
    rd("rst_mid_vid", A_VID, 32'h0);
    rd("rst_mid_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    rst_n = 1'b1;
    rd("post_rst_vid", A_VID, 32'h0);
    rd("post_rst_ram", 32'h0000_0FFC, 32'hA5A5_A5A5);

    @(negedge clk); #1;
    idle(2);
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interfaz_memoria_datos.md
Name: interfaz_memoria_datos

Overview:
- Data-side bus stage directly downstream of the single-cycle processor core.
- Consumes the core's ALU address, store data and memory-write strobe; returns load data to the core.
- Decodes the address into: word-addressed data RAM; button/event registers; frame-tick counter; buffered command FIFO feeding the video/tile renderer over a valid/ready handshake.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 8, video command FIFO depth (power of 2, >=2).
- TICK_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz).
- DEB_CYCLES, 65536, stable cycles required before a debounced button changes (used only with the optional feature).
- NUM_BTN, 4, number of button inputs (<=8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memWr  in  1  store strobe from the core, sampled on clk.
- direc  in  32  byte address from the core ALU, driven every cycle.
- datoOut  in  32  store data from the core.
- datoIn  out  32  load data to the core, combinational from direc.
- botones  in  NUM_BTN  raw asynchronous button pins, active-high.
- video_dato  out  32  head FIFO entry.
- video_valido  out  1  FIFO not empty.
- video_listo  in  1  renderer accepts head entry this cycle.

Behaviour:
- Interface rule: one clock clk; reset rst_n is asynchronous, active-low; every flop clears on assertion, no sync release logic inside the block.
- Reset values: datoIn is combinational (0 for unmapped/peripheral reads after reset); video_valido=0; video_dato=0; all counters, registers and FIFO pointers 0; RAM contents not reset.
- Address map (direc[31:17]==0 required, else unmapped):
  - 0x0000_0000–(RAM_WORDS*4-1): RAM, index direc[log2(RAM_WORDS)+1:2], byte offset ignored.
  - 0x0001_0000 BTN (RO): {0, debounced state}.
  - 0x0001_0004 EVT (R/W1C): bits[NUM_BTN-1:0] sticky rising-edge of debounced state; bit 8 FIFO overflow sticky. A write clears bits set in datoOut. A clear and a new event in the same cycle leave the bit set.
  - 0x0001_0008 TICK (R/W): frame counter, +1 every TICK_DIV cycles, wraps 0xFFFF_FFFF->0. Any write loads 0 and restarts the divider.
  - 0x0001_000C VID: write pushes datoOut into FIFO. Read returns {bit31 full, bits[7:0] occupancy}.
- Unmapped: reads return 0, writes ignored.
- Reads have no side effects: direc changes every cycle regardless of instruction type. Only memWr=1 causes state change.
- RAM: write on clk edge when memWr and RAM hit. Read is asynchronous. Write-then-read of the same address returns new data the following cycle.
- Buttons: 2-flop synchronizer, then debounced state. Edge bits are set one cycle after a debounced 0->1.
- FIFO:
  - Push on VID write if not full. Pop when video_valido && video_listo.
  - Simultaneous push+pop when full: pop occurs, push accepted, occupancy unchanged.
  - Push when full without pop: data dropped, EVT bit 8 set.
  - Pop when empty: ignored.
  - video_dato = head entry; stable while video_valido && !video_listo.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
- Reset mid-operation: FIFO emptied, video_valido drops asynchronously; renderer must discard any partial command.

Optional Feature:
- INTERFAZ_DEBOUNCE_EN defined: per-button counter. Debounced state updates only after synchronized input differs from current state for DEB_CYCLES consecutive cycles; counter resets on any bounce.
- Not defined: debounced state = synchronizer output (2-cycle latency); DEB_CYCLES unused.

Decomposition:
- Package interfaz_pkg: address constants (BASE_BTN, BASE_EVT, BASE_TICK, BASE_VID), EVT_OVF_BIT=8, typedef of the decoded region enum {REG_RAM, REG_BTN, REG_EVT, REG_TICK, REG_VID, REG_NONE}.
- One sub-module: fifo_video (parametrised synchronous FIFO with push/pop/full/empty/count).

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then direc=0x13 -> datoIn=0xDEADBEEF. Write to 0x0002_0000, then read -> 0.
- Raise botones[2] (feature off) -> BTN reads 0x4 within 2 cycles; EVT=0x4 on next cycle. Write 0x4 to EVT -> EVT=0.
- TICK_DIV=4, run 20 cycles -> TICK=5. Write TICK -> reads 0; 4 cycles later reads 1.
- video_listo=0; push 9 words 1..9 (FIFO_DEPTH=8) -> VID read=0x8000_0008, EVT bit 8 set, word 9 lost. Then video_listo=1 -> words 1..8 emitted in order, video_valido drops.
- FIFO full, push and pop in the same cycle -> occupancy stays 8, EVT bit 8 not set.
- rst_n low mid-drain -> video_valido=0 immediately, VID reads 0, RAM data retained.
